// File: rtl/rr_arbiter.sv
// Round-robin arbiter for NREQ requesters with grant locking and registered one-hot grant.
// Define ARB_HOLD_TIMEOUT_EN to cap each owner at MAX_HOLD cycles while others wait.
module rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  win;
  logic            found, owner_req, take;
  logic [IDW:0]    sum;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // The owner is never a candidate; in IDLE gnt_q is zero so cand is just req.
  assign cand      = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!found && cand[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: take = found;
      default: begin
        if (owner_req) begin
`ifdef ARB_HOLD_TIMEOUT_EN
          if (hold_q != HW'(MAX_HOLD-1)) hold_d = hold_q + 1'b1;
          else if (found)                take   = 1'b1;
`endif
        end else if (found) begin
          take = 1'b1;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
    if (take) begin
      gnt_d   = NREQ'(1) << win;
      ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      state_d = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) gnt_id = gnt_id | IDW'(i);
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a 4-requester instance and a 3-requester wrap instance.
module tb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic [2:0] req3 = '0;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       gnt_valid3;

  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];
  logic [2:0] exp3_q[$];

  rr_arbiter #(.NREQ(4), .MAX_HOLD(4)) u_dut (
    .clk(clk), .reset(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid));

  rr_arbiter #(.NREQ(3), .MAX_HOLD(4)) u_dut3 (
    .clk(clk), .reset(rst_n), .req(req3),
    .gnt(gnt3), .gnt_id(gnt_id3), .gnt_valid(gnt_valid3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Drive req ahead of the edge, queue the expected grant, compare just after the edge.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg);
    logic [3:0] e;
    req = r;
    exp_q.push_back(eg);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({tag, ".gnt"}, 32'(gnt), 32'(e));
    chk({tag, ".id"}, 32'(gnt_id), 32'(enc(e)));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(|e));
  endtask

  task automatic step3(input string tag, input logic [2:0] r, input logic [2:0] eg);
    logic [2:0] e;
    req3 = r;
    exp3_q.push_back(eg);
    @(posedge clk); #1;
    e = exp3_q.pop_front();
    chk({tag, ".gnt3"}, 32'(gnt3), 32'(e));
    chk({tag, ".id3"}, 32'(gnt_id3), 32'(enc({1'b0, e})));
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.id", 32'(gnt_id), 32'h0);
    chk("rst.vld", 32'(gnt_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    step("single", 4'b0001, 4'b0001);
    step("release", 4'b0000, 4'b0000);

    // Lock with all requesting, then zero-bubble handoff.
    rst_pulse();
    for (int i = 0; i < 3; i++) step("lock", 4'b1111, 4'b0001);
    step("handoff", 4'b1110, 4'b0010);
    step("idle", 4'b0000, 4'b0000);

    // Fairness with wrap 3 -> 0.
    rst_pulse();
    step("rr0", 4'b1111, 4'b0001);
    step("rr1", 4'b1110, 4'b0010);
    step("rr2", 4'b1101, 4'b0100);
    step("rr3", 4'b1011, 4'b1000);
    step("rr4", 4'b0111, 4'b0001);

    // Asynchronous reset mid-grant, then restart from ptr=0.
    step("own2", 4'b0100, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.gnt", 32'(gnt), 32'h0);
    chk("midrst.vld", 32'(gnt_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step("post_rst", 4'b1100, 4'b0100);
    step("idle2", 4'b0000, 4'b0000);

    // Contention between 0 and 3.
    rst_pulse();
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("to0", 4'b1001, 4'b0001);
      for (int i = 0; i < 4; i++) step("to3", 4'b1001, 4'b1000);
    end
`else
    for (int i = 0; i < 12; i++) step("hold0", 4'b1001, 4'b0001);
`endif
    step("idle3", 4'b0000, 4'b0000);

    // A lone requester never loses the grant.
    rst_pulse();
    for (int i = 0; i < 10; i++) step("lone", 4'b0001, 4'b0001);
    step("idle4", 4'b0000, 4'b0000);

    // Non-power-of-two wrap: ptr=2 after granting 1, search 2 -> 0.
    rst_pulse();
    step3("n3a", 3'b010, 3'b010);
    step3("n3b", 3'b000, 3'b000);
    step3("n3c", 3'b011, 3'b001);
    step3("n3d", 3'b000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1);
  end
endmodule
